// File: rtl/core_pkg.sv
// Shared register-file types.
//   reg_idx_t / reg_data_t : default index and data widths of the core's register file
//   clr_state_e            : bulk-clear sequencer states
package core_pkg;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned IDX_W    = $clog2(NUM_REGS);

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;
endpackage

// File: rtl/regfile_clear_seq.sv
// Bulk-clear sequencer: walks the register array zeroing one entry per cycle.
//   clk, rstN  : clock, async active-low reset
//   clearReq   : start request, honoured only in IDLE
//   clrActive  : high for exactly NumRegs cycles while clearing
//   clrIdx     : entry zeroed at the coming edge
//   clrWe      : zero-write strobe for clrIdx
module regfile_clear_seq
  import core_pkg::*;
#(
  parameter int NumRegs    = 16,
  parameter int IndexWidth = $clog2(NumRegs)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  clearReq,
  output logic                  clrActive,
  output logic [IndexWidth-1:0] clrIdx,
  output logic                  clrWe
);
  localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(NumRegs - 1);

  clr_state_e            r_state;
  logic [IndexWidth-1:0] r_cnt;
  logic                  r_active;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clearReq) begin
            r_state  <= CLEAR;
            r_cnt    <= '0;
            r_active <= 1'b1;
          end
        end
        CLEAR: begin
          // last entry zeroed on this edge; counter parks at 0 instead of wrapping
          if (r_cnt == LastIdx) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_active <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign clrActive = r_active;
  assign clrIdx    = r_cnt;
  assign clrWe     = r_active;
endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file with busy scoreboard and bulk clear.
//   writeEn/Addr/Data : M write ports, highest port index wins on address collision
//   readAddr/Data/Busy: N combinational read ports, optional same-cycle bypass
//   reserveEn/Addr    : marks a destination busy at the next edge
//   clearReq/clearBusy: sequenced zeroing of the whole array
module register_file_mp
  import core_pkg::*;
#(
  parameter int DataWidth     = DATA_W,
  parameter int NumRegs       = NUM_REGS,
  parameter int IndexWidth    = $clog2(NumRegs),
  parameter int NumReadPorts  = 2,
  parameter int NumWritePorts = 2,
  parameter int ZeroReg       = 0,
  parameter int Bypass        = 1
) (
  input  logic                                     clk,
  input  logic                                     rstN,
  input  logic [NumWritePorts-1:0]                 writeEn,
  input  logic [NumWritePorts-1:0][IndexWidth-1:0] writeAddr,
  input  logic [NumWritePorts-1:0][DataWidth-1:0]  writeData,
  input  logic [NumReadPorts-1:0][IndexWidth-1:0]  readAddr,
  output logic [NumReadPorts-1:0][DataWidth-1:0]   readData,
  output logic [NumReadPorts-1:0]                  readBusy,
  input  logic                                     reserveEn,
  input  logic [IndexWidth-1:0]                    reserveAddr,
  input  logic                                     clearReq,
  output logic                                     clearBusy
);
  logic [NumRegs-1:0][DataWidth-1:0] r_regs;
  logic [NumRegs-1:0]                r_busy;

  logic                              w_clrActive, w_clrWe;
  logic [IndexWidth-1:0]             w_clrIdx;
  logic                              w_clrStart, w_rsvEn;
  logic [NumWritePorts-1:0]          w_we;
  logic [NumRegs-1:0]                w_hit;
  logic [NumRegs-1:0][DataWidth-1:0] w_wdata;

  regfile_clear_seq #(.NumRegs(NumRegs), .IndexWidth(IndexWidth)) u_clr (
    .clk      (clk),
    .rstN     (rstN),
    .clearReq (clearReq),
    .clrActive(w_clrActive),
    .clrIdx   (w_clrIdx),
    .clrWe    (w_clrWe)
  );

  assign w_clrStart = clearReq & ~w_clrActive;
  assign w_rsvEn    = reserveEn & ~w_clrActive & ~((ZeroReg != 0) && (reserveAddr == '0));

  // Port writes are dead while clearing and never reach a hardwired zero reg;
  // masking here keeps bypass consistent with what actually lands.
  for (genvar p = 0; p < NumWritePorts; p++) begin : g_wport
    assign w_we[p] = writeEn[p] & ~w_clrActive & ~((ZeroReg != 0) && (writeAddr[p] == '0));
  end

  // Per-register write resolve: ascending scan so the highest port overrides.
  for (genvar r = 0; r < NumRegs; r++) begin : g_reg
    logic                 l_hit;
    logic [DataWidth-1:0] l_data;
    always_comb begin
      l_hit  = 1'b0;
      l_data = '0;
      for (int p = 0; p < NumWritePorts; p++) begin
        if (w_we[p] && (writeAddr[p] == IndexWidth'(r))) begin
          l_hit  = 1'b1;
          l_data = writeData[p];
        end
      end
    end
    assign w_hit[r]   = l_hit;
    assign w_wdata[r] = l_data;
  end

  for (genvar i = 0; i < NumReadPorts; i++) begin : g_rport
    logic                 l_hit;
    logic [DataWidth-1:0] l_data;
    logic                 l_zero;
    always_comb begin
      l_hit  = 1'b0;
      l_data = '0;
      for (int p = 0; p < NumWritePorts; p++) begin
        if (w_we[p] && (writeAddr[p] == readAddr[i])) begin
          l_hit  = 1'b1;
          l_data = writeData[p];
        end
      end
    end
    assign l_zero      = (ZeroReg != 0) && (readAddr[i] == '0);
    assign readData[i] = l_zero                     ? '0     :
                         ((Bypass != 0) && l_hit)   ? l_data : r_regs[readAddr[i]];
    assign readBusy[i] = l_zero                     ? 1'b0   :
                         ((Bypass != 0) && l_hit)   ? 1'b0   : r_busy[readAddr[i]];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_regs <= '0;
      r_busy <= '0;
    end else begin
      for (int r = 0; r < NumRegs; r++) begin
        if (w_clrWe && (w_clrIdx == IndexWidth'(r))) r_regs[r] <= '0;
        else if (w_hit[r])                           r_regs[r] <= w_wdata[r];
        // clear start drops every reservation; reserve beats a same-cycle write
        if (w_clrStart)                                       r_busy[r] <= 1'b0;
        else if (w_rsvEn && (reserveAddr == IndexWidth'(r)))  r_busy[r] <= 1'b1;
        else if (w_hit[r])                                    r_busy[r] <= 1'b0;
      end
    end
  end

  assign clearBusy = w_clrActive;
endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;
  import core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rstN;
  logic [1:0]            writeEn;
  logic [1:0][3:0]       writeAddr;
  logic [1:0][15:0]      writeData;
  logic [1:0][3:0]       readAddr;
  logic                  reserveEn;
  logic [3:0]            reserveAddr;
  logic                  clearReq;

  // instance 0: ZeroReg=1 Bypass=1 ; instance 1: ZeroReg=0 Bypass=0
  logic [1:0][1:0][15:0] rd;
  logic [1:0][1:0]       rb;
  logic [1:0]            cb;

  register_file_mp #(.ZeroReg(1), .Bypass(1)) dut_a (
    .clk(clk), .rstN(rstN), .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .readAddr(readAddr), .readData(rd[0]), .readBusy(rb[0]), .reserveEn(reserveEn),
    .reserveAddr(reserveAddr), .clearReq(clearReq), .clearBusy(cb[0]));

  register_file_mp #(.ZeroReg(0), .Bypass(0)) dut_b (
    .clk(clk), .rstN(rstN), .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
    .readAddr(readAddr), .readData(rd[1]), .readBusy(rb[1]), .reserveEn(reserveEn),
    .reserveAddr(reserveAddr), .clearReq(clearReq), .clearBusy(cb[1]));

  typedef struct packed {
    logic [1:0][1:0][15:0] rd;
    logic [1:0][1:0]       rb;
    logic [1:0]            cb;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // reference model: register contents, busy bits, clear progress per instance
  reg_data_t m_regs [2][16];
  bit        m_busy [2][16];
  bit        m_act  [2];
  int        m_left [2];   // entries still to be zeroed by the clear walk
  int        m_pos  [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) begin m_regs[k][r] = '0; m_busy[k][r] = 1'b0; end
      m_act[k] = 1'b0; m_left[k] = 0; m_pos[k] = 0;
    end
  endfunction

  function automatic bit dropped(int k, int a);
    return (k == 0) && (a == 0);
  endfunction

  function automatic exp_t calc();
    exp_t e;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      e.cb[k] = m_act[k];
      for (int i = 0; i < 2; i++) begin
        int a; bit hit; reg_data_t d;
        a = int'(readAddr[i]); hit = 1'b0; d = '0;
        for (int p = 0; p < 2; p++)
          if (writeEn[p] && !m_act[k] && !dropped(k, int'(writeAddr[p])) && int'(writeAddr[p]) == a) begin
            hit = 1'b1; d = writeData[p];
          end
        if (dropped(k, a))    begin e.rd[k][i] = '0; e.rb[k][i] = 1'b0; end
        else if (k == 0 && hit) begin e.rd[k][i] = d;  e.rb[k][i] = 1'b0; end
        else begin e.rd[k][i] = m_regs[k][a]; e.rb[k][i] = m_busy[k][a]; end
      end
    end
    return e;
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      if (m_act[k]) begin
        m_regs[k][m_pos[k]] = '0;
        m_pos[k]++; m_left[k]--;
        if (m_left[k] == 0) m_act[k] = 1'b0;
      end else begin
        for (int p = 0; p < 2; p++)
          if (writeEn[p] && !dropped(k, int'(writeAddr[p]))) begin
            m_regs[k][writeAddr[p]] = writeData[p];
            m_busy[k][writeAddr[p]] = 1'b0;
          end
        if (reserveEn && !dropped(k, int'(reserveAddr))) m_busy[k][reserveAddr] = 1'b1;
        if (clearReq) begin
          for (int r = 0; r < 16; r++) m_busy[k][r] = 1'b0;
          m_act[k] = 1'b1; m_left[k] = 16; m_pos[k] = 0;
        end
      end
    end
  endfunction

  // called at a falling edge with inputs already driven
  task automatic step();
    if (!rstN) model_reset();
    q.push_back(calc());
    @(posedge clk);
    if (rstN) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    writeEn = '0; reserveEn = 1'b0; clearReq = 1'b0;
  endtask

  task automatic read_all();
    idle();
    for (int r = 0; r < 16; r++) begin
      readAddr[0] = 4'(r); readAddr[1] = 4'(15 - r);
      step();
    end
  endtask

  task automatic fill();
    idle();
    for (int r = 0; r < 16; r += 2) begin
      writeEn = 2'b11;
      writeAddr[0] = 4'(r);     writeData[0] = 16'(r * 16'h0101);
      writeAddr[1] = 4'(r + 1); writeData[1] = 16'((r + 1) * 16'h0101);
      step();
    end
    idle();
  endtask

  task automatic check_cnt(string name, int act, int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // monitor: outputs are combinational, sampled mid-low-phase
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 2; k++) begin
          for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (rd[k][i] !== e.rd[k][i]) begin
              n_fail++;
              $display("FAIL readData inst%0d port%0d addr=%0d: got %h expected %h",
                       k, i, readAddr[i], rd[k][i], e.rd[k][i]);
            end
            n_chk++;
            if (rb[k][i] !== e.rb[k][i]) begin
              n_fail++;
              $display("FAIL readBusy inst%0d port%0d addr=%0d: got %b expected %b",
                       k, i, readAddr[i], rb[k][i], e.rb[k][i]);
            end
          end
          n_chk++;
          if (cb[k] !== e.cb[k]) begin
            n_fail++;
            $display("FAIL clearBusy inst%0d: got %b expected %b", k, cb[k], e.cb[k]);
          end
        end
      end
    end
  end

  initial begin
    int hi_a, hi_b, wait_cyc;
    rstN = 1'b0; idle(); writeAddr = '0; writeData = '0; readAddr = '0; reserveAddr = '0;
    model_reset();
    @(negedge clk);
    step(); step();
    rstN = 1'b1;

    // reset contents
    read_all();

    // two ports on reg 5, same-cycle read
    writeEn = 2'b11; writeAddr[0] = 4'd5; writeData[0] = 16'h1111;
    writeAddr[1] = 4'd5; writeData[1] = 16'h2222; readAddr[0] = 4'd5; readAddr[1] = 4'd5;
    step(); idle(); step();

    // reserve / release reg 3
    reserveEn = 1'b1; reserveAddr = 4'd3; readAddr[0] = 4'd3; readAddr[1] = 4'd2;
    step(); idle(); step();
    writeEn = 2'b01; writeAddr[0] = 4'd3; writeData[0] = 16'hBEEF;
    step(); idle(); step();
    writeEn = 2'b10; writeAddr[1] = 4'd3; writeData[1] = 16'h1234;
    reserveEn = 1'b1; reserveAddr = 4'd3;
    step(); idle(); step();

    // writes and reserve on reg 0
    writeEn = 2'b01; writeAddr[0] = 4'd0; writeData[0] = 16'hFFFF;
    reserveEn = 1'b1; reserveAddr = 4'd0; readAddr[0] = 4'd0; readAddr[1] = 4'd0;
    step(); idle(); step();

    // full clear with writes/reserves/requests fired at it throughout
    fill();
    clearReq = 1'b1; step();
    hi_a = 0; hi_b = 0;
    for (int c = 0; c < 20; c++) begin
      if (cb[0]) hi_a++;
      if (cb[1]) hi_b++;
      writeEn = 2'($urandom); writeAddr[0] = 4'($urandom); writeAddr[1] = 4'($urandom);
      writeData[0] = 16'($urandom); writeData[1] = 16'($urandom);
      reserveEn = 1'($urandom); reserveAddr = 4'($urandom);
      clearReq = (c < 14) ? 1'($urandom) : 1'b0;
      readAddr[0] = 4'($urandom); readAddr[1] = 4'($urandom);
      if (c >= 15) idle();
      step();
    end
    check_cnt("clear_cycles_inst0", hi_a, 16);
    check_cnt("clear_cycles_inst1", hi_b, 16);
    idle();
    read_all();

    // reset mid-clear
    fill();
    reserveEn = 1'b1; reserveAddr = 4'd9; step(); idle();
    clearReq = 1'b1; step(); idle();
    for (int c = 0; c < 7; c++) step();
    rstN = 1'b0; readAddr[0] = 4'd12; readAddr[1] = 4'd15;
    step();
    rstN = 1'b1;
    read_all();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      writeEn = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        writeAddr[p] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
        writeData[p] = 16'($urandom);
      end
      for (int i = 0; i < 2; i++)
        readAddr[i] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      reserveEn = 1'($urandom); reserveAddr = 4'($urandom);
      clearReq = ($urandom_range(0, 59) == 0);
      step();
    end
    idle();
    read_all();

    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin @(negedge clk); wait_cyc++; end
    #4;
    if (q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
